writeback_arb: RTL and testbench

WRITEBACK_ARB -- requirements
Module: writeback_arb

---
 rtl/writeback_arb.sv | 147 ++++++++++++++
 tb/tb_writeback_arb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arb.sv
// Writeback arbiter: round-robin grant of up to two register-file write ports
// among the execution units, with combinational acks and registered writes.
module writeback_arb #(
  parameter int unsigned NUNITS = 5,
  parameter int unsigned DW     = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu1_done,
  input  logic [5:0]    alu1_rd,
  input  logic [DW-1:0] alu1_data,
  output logic          alu1_ack,
  input  logic          alu2_done,
  input  logic [5:0]    alu2_rd,
  input  logic [DW-1:0] alu2_data,
  output logic          alu2_ack,
  input  logic          advint_done,
  input  logic [5:0]    advint_rd,
  input  logic [DW-1:0] advint_data,
  input  logic [5:0]    advint_rd2,
  input  logic [DW-1:0] advint_data2,
  output logic          advint_ack,
  input  logic          memunit_done,
  input  logic [5:0]    memunit_rd,
  input  logic [DW-1:0] memunit_data,
  output logic          memunit_ack,
  input  logic          branch_done,
  input  logic [5:0]    branch_rd,
  input  logic [DW-1:0] branch_data,
  output logic          branch_ack,
  output logic          wr1_en,
  output logic [5:0]    wr1_rn,
  output logic [DW-1:0] wr1_data,
  output logic          wr2_en,
  output logic [5:0]    wr2_rn,
  output logic [DW-1:0] wr2_data,
  output logic [5:0]    reg1_finished,
  output logic [5:0]    reg2_finished
);

  localparam int unsigned PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

  logic          done_v  [NUNITS];
  logic [5:0]    rd_v    [NUNITS];
  logic [5:0]    rd2_v   [NUNITS];
  logic [DW-1:0] data_v  [NUNITS];
  logic [DW-1:0] data2_v [NUNITS];
  logic [NUNITS-1:0] ack_v;

  assign done_v[0] = alu1_done;    assign rd_v[0] = alu1_rd;    assign data_v[0] = alu1_data;
  assign done_v[1] = alu2_done;    assign rd_v[1] = alu2_rd;    assign data_v[1] = alu2_data;
  assign done_v[2] = advint_done;  assign rd_v[2] = advint_rd;  assign data_v[2] = advint_data;
  assign done_v[3] = memunit_done; assign rd_v[3] = memunit_rd; assign data_v[3] = memunit_data;
  assign done_v[4] = branch_done;  assign rd_v[4] = branch_rd;  assign data_v[4] = branch_data;

  // Only advint has a second destination; the others present a permanent "none".
  assign rd2_v[0] = '0; assign data2_v[0] = '0;
  assign rd2_v[1] = '0; assign data2_v[1] = '0;
  assign rd2_v[2] = advint_rd2; assign data2_v[2] = advint_data2;
  assign rd2_v[3] = '0; assign data2_v[3] = '0;
  assign rd2_v[4] = '0; assign data2_v[4] = '0;

  assign alu1_ack    = ack_v[0];
  assign alu2_ack    = ack_v[1];
  assign advint_ack  = ack_v[2];
  assign memunit_ack = ack_v[3];
  assign branch_ack  = ack_v[4];

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int unsigned off);
    logic [PW:0] s;
    s = {1'b0, base} + (PW+1)'(off);
    if (s >= (PW+1)'(NUNITS)) s = s - (PW+1)'(NUNITS);
    return s[PW-1:0];
  endfunction

  logic [PW-1:0] ptr, idx, last_idx;
  logic [1:0]    used;
  logic          any_grant;
  logic [5:0]    dest;
  logic [DW-1:0] dest_data;
  logic          n_en1, n_en2;
  logic [5:0]    n_rn1, n_rn2;
  logic [DW-1:0] n_d1, n_d2;

  always_comb begin
    ack_v     = '0;
    used      = '0;
    any_grant = 1'b0;
    last_idx  = ptr;
    idx       = ptr;
    dest      = '0;
    dest_data = '0;
    n_en1 = 1'b0; n_rn1 = '0; n_d1 = '0;
    n_en2 = 1'b0; n_rn2 = '0; n_d2 = '0;
    for (int unsigned i = 0; i < NUNITS; i++) begin
      idx       = rot(ptr, i);
      dest      = (rd_v[idx] != '0) ? rd_v[idx] : rd2_v[idx];
      dest_data = (rd_v[idx] != '0) ? data_v[idx] : data2_v[idx];
      if (done_v[idx] && !rst) begin
        if (rd_v[idx] == '0 && rd2_v[idx] == '0) begin
          ack_v[idx] = 1'b1;
        end else if (rd_v[idx] != '0 && rd2_v[idx] != '0) begin
          // Dual-destination request takes both ports or waits for a later cycle.
          if (used == 2'd0) begin
            n_en1 = 1'b1; n_rn1 = rd_v[idx];  n_d1 = data_v[idx];
            n_en2 = 1'b1; n_rn2 = rd2_v[idx]; n_d2 = data2_v[idx];
            used = 2'd2; ack_v[idx] = 1'b1; any_grant = 1'b1; last_idx = idx;
          end
        end else if (used == 2'd0) begin
          n_en1 = 1'b1; n_rn1 = dest; n_d1 = dest_data;
          used = 2'd1; ack_v[idx] = 1'b1; any_grant = 1'b1; last_idx = idx;
        end else if (used == 2'd1 && dest != n_rn1) begin
          n_en2 = 1'b1; n_rn2 = dest; n_d2 = dest_data;
          used = 2'd2; ack_v[idx] = 1'b1; any_grant = 1'b1; last_idx = idx;
        end
      end
    end
  end

  logic          r_en1, r_en2;
  logic [5:0]    r_rn1, r_rn2;
  logic [DW-1:0] r_d1, r_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      r_en1 <= 1'b0; r_rn1 <= '0; r_d1 <= '0;
      r_en2 <= 1'b0; r_rn2 <= '0; r_d2 <= '0;
    end else begin
      if (any_grant) ptr <= rot(last_idx, 1);
      r_en1 <= n_en1; r_rn1 <= n_rn1; r_d1 <= n_d1;
      r_en2 <= n_en2; r_rn2 <= n_rn2; r_d2 <= n_d2;
    end
  end

  // Gating with rst suppresses a write already registered when reset arrives.
  assign wr1_en   = r_en1 & ~rst;
  assign wr1_rn   = rst ? '0 : r_rn1;
  assign wr1_data = rst ? '0 : r_d1;
  assign wr2_en   = r_en2 & ~rst;
  assign wr2_rn   = rst ? '0 : r_rn2;
  assign wr2_data = rst ? '0 : r_d2;

  assign reg1_finished = wr1_en ? wr1_rn : '0;
  assign reg2_finished = wr2_en ? wr2_rn : '0;

endmodule

// File: tb/tb_writeback_arb.sv
// Scoreboard bench for writeback_arb: directed scenarios plus randomized
// request traffic checked against a rotation-order reference model.
module tb_writeback_arb;
  localparam int N  = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          done [N];
  logic [5:0]    rd   [N];
  logic [DW-1:0] data [N];
  logic [5:0]    adv_rd2;
  logic [DW-1:0] adv_d2;
  logic [N-1:0]  ack;
  logic          wr1_en, wr2_en;
  logic [5:0]    wr1_rn, wr2_rn, reg1_finished, reg2_finished;
  logic [DW-1:0] wr1_data, wr2_data;

  always #5 clk = ~clk;

  writeback_arb #(.NUNITS(5), .DW(64)) dut (
    .clk(clk), .rst(rst),
    .alu1_done(done[0]), .alu1_rd(rd[0]), .alu1_data(data[0]), .alu1_ack(ack[0]),
    .alu2_done(done[1]), .alu2_rd(rd[1]), .alu2_data(data[1]), .alu2_ack(ack[1]),
    .advint_done(done[2]), .advint_rd(rd[2]), .advint_data(data[2]),
    .advint_rd2(adv_rd2), .advint_data2(adv_d2), .advint_ack(ack[2]),
    .memunit_done(done[3]), .memunit_rd(rd[3]), .memunit_data(data[3]), .memunit_ack(ack[3]),
    .branch_done(done[4]), .branch_rd(rd[4]), .branch_data(data[4]), .branch_ack(ack[4]),
    .wr1_en(wr1_en), .wr1_rn(wr1_rn), .wr1_data(wr1_data),
    .wr2_en(wr2_en), .wr2_rn(wr2_rn), .wr2_data(wr2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
  );

  typedef struct {
    logic          en1;
    logic [5:0]    rn1;
    logic [DW-1:0] d1;
    logic          en2;
    logic [5:0]    rn2;
    logic [DW-1:0] d2;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_w;
  int           checks = 0;
  int           errors = 0;
  int           mptr = 0;
  logic [N-1:0] last_ack;
  logic [N-1:0] last_dut_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: visit requesters in rotation order from the pointer, handing out
  // free ports greedily; same-register and port-starved requests wait.
  task automatic model_step(output logic [N-1:0] a, output wr_t w, output int np);
    int used;
    a = '0; w = '{default: '0}; used = 0; np = mptr;
    if (rst) np = 0;
    else begin
      for (int k = 0; k < N; k++) begin
        int         u;
        logic [5:0] r1, r2, dst;
        logic [DW-1:0] dd;
        u  = (mptr + k) % N;
        r1 = rd[u];
        r2 = (u == 2) ? adv_rd2 : 6'd0;
        dst = (r1 != 0) ? r1 : r2;
        dd  = (r1 != 0) ? data[u] : adv_d2;
        if (done[u]) begin
          if (r1 == 0 && r2 == 0) a[u] = 1'b1;
          else if (r1 != 0 && r2 != 0) begin
            if (used == 0) begin
              w.en1 = 1'b1; w.rn1 = r1; w.d1 = data[u];
              w.en2 = 1'b1; w.rn2 = r2; w.d2 = adv_d2;
              used = 2; a[u] = 1'b1; np = (u + 1) % N;
            end
          end else if (used == 0) begin
            w.en1 = 1'b1; w.rn1 = dst; w.d1 = dd;
            used = 1; a[u] = 1'b1; np = (u + 1) % N;
          end else if (used == 1 && dst != w.rn1) begin
            w.en2 = 1'b1; w.rn2 = dst; w.d2 = dd;
            used = 2; a[u] = 1'b1; np = (u + 1) % N;
          end
        end
      end
    end
  endtask

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle();
    logic [N-1:0] ea;
    wr_t          w;
    int           np;
    #1;
    model_step(ea, w, np);
    last_dut_ack = ack;
    chk("ack", ack, ea);
    exp_q.push_back(w);
    last_ack = ea;
    @(posedge clk);
    #2;
    mptr = np;
    chk("ptr", dut.ptr, np);
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_w = exp_q.pop_front();
      chk("wr1_en", wr1_en, mon_w.en1);
      chk("wr1_rn", wr1_rn, mon_w.rn1);
      chk("wr2_en", wr2_en, mon_w.en2);
      chk("wr2_rn", wr2_rn, mon_w.rn2);
      chk("reg1_finished", reg1_finished, mon_w.en1 ? mon_w.rn1 : 6'd0);
      chk("reg2_finished", reg2_finished, mon_w.en2 ? mon_w.rn2 : 6'd0);
      if (mon_w.en1) chk("wr1_data", wr1_data, mon_w.d1);
      if (mon_w.en2) chk("wr2_data", wr2_data, mon_w.d2);
    end
  end

  task automatic clr();
    for (int u = 0; u < N; u++) begin
      done[u] = 1'b0; rd[u] = '0; data[u] = '0;
    end
    adv_rd2 = '0; adv_d2 = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [5:0] rnd_rd();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 6'd0;
    if (r == 9) return 6'd63;
    return 6'(r - 1);
  endfunction

  task automatic new_req(input int u);
    done[u] = 1'b1;
    rd[u]   = rnd_rd();
    data[u] = {$urandom, $urandom};
    if (u == 2) begin
      adv_rd2 = rnd_rd();
      adv_d2  = {$urandom, $urandom};
    end
  endtask

  task automatic update_units();
    for (int u = 0; u < N; u++) begin
      if (last_ack[u] || !done[u]) begin
        if ($urandom_range(0, 99) < 60) new_req(u);
        else done[u] = 1'b0;
      end
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    last_ack = '0;
    cycle();
    chk("reset_wr1_en", wr1_en, 1'b0);
    chk("reset_reg1_finished", reg1_finished, 6'd0);
    do_reset();

    // Two single-destination units at opposite ends of the rotation.
    done[0] = 1'b1; rd[0] = 6'd5;  data[0] = 64'hAA;
    done[4] = 1'b1; rd[4] = 6'd63; data[4] = 64'h100;
    cycle();
    chk("t29_ack", last_dut_ack, 5'b10001);
    chk("t29_wr1", {wr1_en, wr1_rn}, {1'b1, 6'd5});
    chk("t29_wr2", {wr2_en, wr2_rn}, {1'b1, 6'd63});
    chk("t29_d1", wr1_data, 64'hAA);
    chk("t29_d2", wr2_data, 64'h100);
    chk("t29_fin", {reg1_finished, reg2_finished}, {6'd5, 6'd63});
    chk("t29_ptr", dut.ptr, 0);
    clr();
    cycle();

    // Three requesters, two ports.
    done[0] = 1'b1; rd[0] = 6'd1; data[0] = 64'h11;
    done[1] = 1'b1; rd[1] = 6'd2; data[1] = 64'h22;
    done[3] = 1'b1; rd[3] = 6'd3; data[3] = 64'h33;
    cycle();
    chk("t30_ack0", last_dut_ack, 5'b00011);
    done[0] = 1'b0; done[1] = 1'b0;
    cycle();
    chk("t30_ack1", last_dut_ack, 5'b01000);
    chk("t30_wr1", {wr1_en, wr1_rn, wr2_en}, {1'b1, 6'd3, 1'b0});
    clr();
    cycle();

    // Dual-destination advint skipped behind a single-port grant.
    do_reset();
    done[0] = 1'b1; rd[0] = 6'd4; data[0] = 64'h44;
    done[2] = 1'b1; rd[2] = 6'd7; data[2] = 64'h77; adv_rd2 = 6'd8; adv_d2 = 64'h88;
    cycle();
    chk("t31_ack0", last_dut_ack, 5'b00001);
    chk("t31_ptr", dut.ptr, 1);
    done[0] = 1'b0;
    cycle();
    chk("t31_ack1", last_dut_ack, 5'b00100);
    chk("t31_wr", {wr1_en, wr1_rn, wr2_en, wr2_rn}, {1'b1, 6'd7, 1'b1, 6'd8});
    clr();
    cycle();

    // Store with no destination: immediate ack, no write, pointer unchanged.
    done[3] = 1'b1; rd[3] = 6'd0;
    cycle();
    chk("t32_ack", last_dut_ack, 5'b01000);
    chk("t32_wr", {wr1_en, wr2_en}, 2'b00);
    chk("t32_ptr", dut.ptr, 3);
    clr();
    cycle();

    // Same destination from two units: serialized over two cycles.
    do_reset();
    done[0] = 1'b1; rd[0] = 6'd9; data[0] = 64'h90;
    done[1] = 1'b1; rd[1] = 6'd9; data[1] = 64'h91;
    cycle();
    chk("t33_ack0", last_dut_ack, 5'b00001);
    chk("t33_wr_a", {wr1_en, wr1_rn, wr2_en}, {1'b1, 6'd9, 1'b0});
    done[0] = 1'b0;
    cycle();
    chk("t33_ack1", last_dut_ack, 5'b00010);
    chk("t33_wr_b", {wr1_en, wr1_rn, wr1_data}, {1'b1, 6'd9, 64'h91});
    clr();
    cycle();

    // Reset right after a grant suppresses the pending write.
    done[2] = 1'b1; rd[2] = 6'd5; data[2] = 64'h55;
    cycle();
    clr();
    rst = 1'b1;
    #1;
    chk("t34_en_gated", {wr1_en, wr2_en}, 2'b00);
    chk("t34_fin_gated", {reg1_finished, reg2_finished}, 12'd0);
    cycle();
    rst = 1'b0;
    chk("t34_ptr", dut.ptr, 0);
    chk("t34_out", {wr1_en, wr2_en, reg1_finished, reg2_finished}, 14'd0);
    cycle();

    // Randomized traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      cycle();
      update_units();
    end
    rst = 1'b0;
    clr();
    cycle();
    cycle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
